// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, data-memory freeze,
// ID-stage branch flushes, memory watchdog and saturating stall/flush statistics.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_mem_read_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             fault_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [8:0]       wait_inc;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             load_use, mem_stall;
  logic [4:0]       adv_en, en;  // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic             adv_if_fl, adv_id_fl, if_fl, id_fl;

  assign load_use  = id_ex_mem_read_i & (id_ex_rt_i != 5'd0) &
                     ((id_ex_rt_i == if_id_rs_i) | (id_ex_rt_i == if_id_rt_i));
  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign wait_inc  = {1'b0, wait_q} + 9'd1;

  // Decode for a cycle where memory lets the pipeline move; a load-use stall
  // swallows the branch since the ID instruction will re-resolve it.
  always_comb begin
    adv_en    = 5'b11111;
    adv_if_fl = 1'b0;
    adv_id_fl = 1'b0;
    if (load_use) begin
      adv_en    = 5'b00111;
      adv_id_fl = 1'b1;
    end else if (branch_taken_i | pend_q) begin
      adv_if_fl = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pend_d  = pend_q;
    en      = '0;
    if_fl   = 1'b0;
    id_fl   = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          // The entry cycle already counts toward the watchdog limit.
          state_d = (MAX_WAIT == 1) ? FAULT : MEM_WAIT;
          wait_d  = 8'd1;
          pend_d  = pend_q | branch_taken_i;
        end else begin
          en    = adv_en;
          if_fl = adv_if_fl;
          id_fl = adv_id_fl;
          if (adv_if_fl) pend_d = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready_i) begin
          pend_d = pend_q | branch_taken_i;
          wait_d = wait_inc[7:0];
          if (wait_inc == 9'(MAX_WAIT)) state_d = FAULT;
        end else begin
          en      = adv_en;
          if_fl   = adv_if_fl;
          id_fl   = adv_id_fl;
          state_d = RUN;
          wait_d  = '0;
          if (adv_if_fl) pend_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!en[4] && state_q != FAULT && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    if ((if_fl | id_fl) && flush_q != '1)            flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = en;
  assign if_id_flush_o = if_fl;
  assign id_ex_flush_o = id_fl;
  assign fault_o       = (state_q == FAULT);
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_q;
  assign flush_cnt_o   = flush_q;
endmodule
